// File: rtl/riscv_apu_disp_multi.sv
// APU dispatcher: issues ID-stage requests to the shared APU interconnect and tracks
// up to DEPTH outstanding operations in an in-order FIFO for writeback and hazard checks.
module riscv_apu_disp_multi #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NR_RREGS = 3,
  parameter int unsigned NR_WREGS = 2,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               enable_i,
  input  logic [1:0]                         apu_lat_i,
  input  logic [ADDR_W-1:0]                  apu_waddr_i,
  output logic [ADDR_W-1:0]                  apu_waddr_o,
  output logic                               apu_multicycle_o,
  output logic                               apu_singlecycle_o,
  output logic                               active_o,
  output logic                               stall_o,
  output logic [CNT_W-1:0]                   occupancy_o,
  input  logic [NR_RREGS-1:0][ADDR_W-1:0]    read_regs_i,
  input  logic [NR_RREGS-1:0]                read_regs_valid_i,
  output logic                               read_dep_o,
  input  logic [NR_WREGS-1:0][ADDR_W-1:0]    write_regs_i,
  input  logic [NR_WREGS-1:0]                write_regs_valid_i,
  output logic                               write_dep_o,
  output logic                               perf_type_o,
  output logic                               perf_cont_o,
  output logic                               perf_full_o,
  output logic                               apu_master_req_o,
  output logic                               apu_master_ready_o,
  input  logic                               apu_master_gnt_i,
  input  logic                               apu_master_valid_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam logic [1:0] LAT_SHORT  = 2'd1;
  localparam logic [1:0] LAT_MEDIUM = 2'd2;
  localparam logic [1:0] LAT_MULTI  = 2'd3;

  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [1:0]        lat_q;

  logic active, stall_full, stall_type, stall_nack;
  logic valid_req, accepted, returned_req, push, pop;
  logic rd_hit, wr_hit;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] entry;

  assign active     = (count_q != '0);
  assign stall_full = (count_q == CNT_W'(DEPTH));
  // Ops that could overtake an outstanding one must wait for the FIFO to drain
  assign stall_type = enable_i & active &
                      ((apu_lat_i == LAT_SHORT) | (apu_lat_i == LAT_MULTI) |
                       ((apu_lat_i == LAT_MEDIUM) & (lat_q == LAT_MULTI)));
  assign valid_req    = enable_i & ~stall_full & ~stall_type;
  assign accepted     = valid_req & apu_master_gnt_i;
  assign stall_nack   = valid_req & ~apu_master_gnt_i;
  assign returned_req = valid_req & apu_master_valid_i & ~active;
  assign pop          = apu_master_valid_i & active;
  assign push         = accepted & ~returned_req;

  assign apu_master_req_o   = valid_req;
  assign apu_master_ready_o = 1'b1;
  assign stall_o            = stall_full | stall_type | stall_nack;
  assign perf_full_o        = stall_full;
  assign perf_type_o        = stall_type;
  assign perf_cont_o        = stall_nack;
  assign active_o           = active;
  assign apu_singlecycle_o  = ~active;
  assign apu_multicycle_o   = (lat_q == LAT_MULTI);
  assign occupancy_o        = count_q;
  assign apu_waddr_o        = returned_req ? apu_waddr_i :
                              pop          ? fifo_q[rd_ptr_q] : '0;
  assign read_dep_o         = rd_hit;
  assign write_dep_o        = wr_hit;

  // Hazard check against every live entry; a popping head no longer counts
  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    idx    = '0;
    entry  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = IDX_W'(rd_ptr_q) + IDX_W'(k);
      if (idx >= IDX_W'(DEPTH)) idx = idx - IDX_W'(DEPTH);
      if ((CNT_W'(k) < count_q) && !((k == 0) && pop)) begin
        entry = fifo_q[idx[PTR_W-1:0]];
        for (int unsigned r = 0; r < NR_RREGS; r++)
          if (read_regs_valid_i[r] && (read_regs_i[r] == entry)) rd_hit = 1'b1;
        for (int unsigned w = 0; w < NR_WREGS; w++)
          if (write_regs_valid_i[w] && (write_regs_i[w] == entry)) wr_hit = 1'b1;
      end
    end
    if (valid_req && !returned_req) begin
      for (int unsigned r = 0; r < NR_RREGS; r++)
        if (read_regs_valid_i[r] && (read_regs_i[r] == apu_waddr_i)) rd_hit = 1'b1;
      for (int unsigned w = 0; w < NR_WREGS; w++)
        if (write_regs_valid_i[w] && (write_regs_i[w] == apu_waddr_i)) wr_hit = 1'b1;
    end
  end

  // FIFO storage, pointers, occupancy and last-issued latency class
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      lat_q    <= '0;
    end else begin
      if (valid_req) lat_q <= apu_lat_i;
      if (push) begin
        fifo_q[wr_ptr_q] <= apu_waddr_i;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  spurious_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(apu_master_valid_i && !active && !valid_req))
    else $warning("apu_master_valid_i with nothing outstanding, ignored");
`endif

endmodule

// File: tb/tb_riscv_apu_disp_multi.sv
// Bench for riscv_apu_disp_multi: directed scenarios plus random traffic checked
// against a queue-based reference model of the dispatcher.
module tb_riscv_apu_disp_multi;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned NR_RREGS = 3;
  localparam int unsigned NR_WREGS = 2;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic enable, gnt, valid;
  logic [1:0] lat;
  logic [ADDR_W-1:0] waddr, waddr_o;
  logic multicycle, singlecycle, active, stall;
  logic [CNT_W-1:0] occupancy;
  logic [NR_RREGS-1:0][ADDR_W-1:0] read_regs;
  logic [NR_RREGS-1:0] read_valid;
  logic [NR_WREGS-1:0][ADDR_W-1:0] write_regs;
  logic [NR_WREGS-1:0] write_valid;
  logic read_dep, write_dep, perf_type, perf_cont, perf_full, req, ready;

  riscv_apu_disp_multi #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NR_RREGS(NR_RREGS), .NR_WREGS(NR_WREGS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .apu_lat_i(lat),
    .apu_waddr_i(waddr), .apu_waddr_o(waddr_o), .apu_multicycle_o(multicycle),
    .apu_singlecycle_o(singlecycle), .active_o(active), .stall_o(stall),
    .occupancy_o(occupancy), .read_regs_i(read_regs), .read_regs_valid_i(read_valid),
    .read_dep_o(read_dep), .write_regs_i(write_regs), .write_regs_valid_i(write_valid),
    .write_dep_o(write_dep), .perf_type_o(perf_type), .perf_cont_o(perf_cont),
    .perf_full_o(perf_full), .apu_master_req_o(req), .apu_master_ready_o(ready),
    .apu_master_gnt_i(gnt), .apu_master_valid_i(valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding destinations in issue order, last issued class
  logic [ADDR_W-1:0] q[$];
  logic [1:0] m_lat;
  logic e_vreq, e_ret, e_pop, e_push, e_full, e_type, e_nack, e_rdep, e_wdep;
  logic [ADDR_W-1:0] e_waddr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic hit_r(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < NR_RREGS; i++) if (read_valid[i] && read_regs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic hit_w(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < NR_WREGS; i++) if (write_valid[i] && write_regs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    logic act;
    act     = (q.size() != 0);
    e_full  = (q.size() == DEPTH);
    e_type  = enable && act && (lat == 2'd1 || lat == 2'd3 || (lat == 2'd2 && m_lat == 2'd3));
    e_vreq  = enable && !e_full && !e_type;
    e_ret   = e_vreq && valid && !act;
    e_pop   = valid && act;
    e_push  = e_vreq && gnt && !e_ret;
    e_nack  = e_vreq && !gnt;
    e_waddr = e_ret ? waddr : (e_pop ? q[0] : '0);
    e_rdep  = 1'b0;
    e_wdep  = 1'b0;
    for (int i = 0; i < q.size(); i++)
      if (!(i == 0 && e_pop)) begin
        e_rdep |= hit_r(q[i]);
        e_wdep |= hit_w(q[i]);
      end
    if (e_vreq && !e_ret) begin
      e_rdep |= hit_r(waddr);
      e_wdep |= hit_w(waddr);
    end
  endtask

  task automatic settle(input string tag);
    #1;
    model_eval();
    check_eq({tag, ".waddr"}, 32'(waddr_o), 32'(e_waddr));
    check_eq({tag, ".multi"}, 32'(multicycle), 32'(m_lat == 2'd3));
    check_eq({tag, ".single"}, 32'(singlecycle), 32'(q.size() == 0));
    check_eq({tag, ".active"}, 32'(active), 32'(q.size() != 0));
    check_eq({tag, ".occ"}, 32'(occupancy), 32'(q.size()));
    check_eq({tag, ".stall"}, 32'(stall), 32'(e_full | e_type | e_nack));
    check_eq({tag, ".pfull"}, 32'(perf_full), 32'(e_full));
    check_eq({tag, ".ptype"}, 32'(perf_type), 32'(e_type));
    check_eq({tag, ".pcont"}, 32'(perf_cont), 32'(e_nack));
    check_eq({tag, ".req"}, 32'(req), 32'(e_vreq));
    check_eq({tag, ".ready"}, 32'(ready), 32'd1);
    check_eq({tag, ".rdep"}, 32'(read_dep), 32'(e_rdep));
    check_eq({tag, ".wdep"}, 32'(write_dep), 32'(e_wdep));
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (e_push) q.push_back(waddr);
    if (e_vreq) m_lat = lat;
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [1:0] l, input int a, input logic g, input logic v);
    enable = en; lat = l; waddr = ADDR_W'(a); gnt = g; valid = v;
    read_valid = '0; write_valid = '0;
  endtask

  task automatic issue(input int a);
    drive(1'b1, 2'd2, a, 1'b1, 1'b0);
    settle("issue");
    advance();
  endtask

  initial begin
    rst_n = 1'b0; q.delete(); m_lat = 2'd0;
    read_regs = '0; write_regs = '0;
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    @(negedge clk);
    settle("reset");
    check_eq("reset.single_c", 32'(singlecycle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle op returning with its own request
    drive(1'b1, 2'd1, 5, 1'b1, 1'b1);
    read_regs[0] = 6'd5; read_valid = 3'b001;
    settle("single");
    check_eq("single.waddr_c", 32'(waddr_o), 32'd5);
    check_eq("single.rdep_c", 32'(read_dep), 32'd0);
    advance();
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    settle("single_after");
    check_eq("single.occ_c", 32'(occupancy), 32'd0);

    // Fill to DEPTH, full stall, drain in order
    for (int i = 1; i <= 4; i++) issue(i);
    drive(1'b1, 2'd2, 5, 1'b1, 1'b0);
    settle("full");
    check_eq("full.occ_c", 32'(occupancy), 32'd4);
    check_eq("full.pfull_c", 32'(perf_full), 32'd1);
    check_eq("full.req_c", 32'(req), 32'd0);
    advance();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 2'd0, 0, 1'b0, 1'b1);
      settle("drain");
      check_eq("drain.waddr_c", 32'(waddr_o), 32'(i));
      advance();
    end

    // Push and pop together
    issue(7); issue(9);
    drive(1'b1, 2'd2, 11, 1'b1, 1'b1);
    settle("pushpop");
    check_eq("pushpop.waddr_c", 32'(waddr_o), 32'd7);
    advance();
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    read_regs[0] = 6'd9; read_valid = 3'b001;
    settle("dep9");
    check_eq("pushpop.occ_c", 32'(occupancy), 32'd2);
    check_eq("dep9.rdep_c", 32'(read_dep), 32'd1);
    read_regs[0] = 6'd7;
    settle("dep7");
    check_eq("dep7.rdep_c", 32'(read_dep), 32'd0);
    read_regs[2] = 6'd11; read_valid = 3'b100;
    settle("dep11");
    check_eq("dep11.rdep_c", 32'(read_dep), 32'd1);
    drive(1'b0, 2'd0, 0, 1'b0, 1'b1); settle("pp_drain"); advance();
    settle("pp_drain"); advance();

    // Type stall behind a multicycle op
    drive(1'b1, 2'd3, 20, 1'b1, 1'b0); settle("type_issue"); advance();
    drive(1'b1, 2'd2, 21, 1'b1, 1'b0);
    settle("type_med");
    check_eq("type_med.ptype_c", 32'(perf_type), 32'd1);
    advance();
    drive(1'b1, 2'd1, 21, 1'b1, 1'b0);
    settle("type_short");
    check_eq("type_short.stall_c", 32'(stall), 32'd1);
    advance();
    drive(1'b1, 2'd1, 21, 1'b1, 1'b1);
    settle("type_pop");
    check_eq("type_pop.waddr_c", 32'(waddr_o), 32'd20);
    advance();
    drive(1'b1, 2'd1, 21, 1'b1, 1'b0);
    settle("type_go");
    check_eq("type_go.stall_c", 32'(stall), 32'd0);
    advance();
    drive(1'b0, 2'd0, 0, 1'b0, 1'b1); settle("type_drain"); advance();

    // Interconnect nack
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, 30, 1'b0, 1'b0);
      settle("nack");
      check_eq("nack.pcont_c", 32'(perf_cont), 32'd1);
      advance();
    end
    drive(1'b1, 2'd2, 30, 1'b1, 1'b0); settle("nack_gnt"); advance();
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    settle("nack_after");
    check_eq("nack.occ_c", 32'(occupancy), 32'd1);
    drive(1'b0, 2'd0, 0, 1'b0, 1'b1); settle("nack_drain"); advance();

    // Hazard release on return, write hazard, reset mid-operation
    issue(3); issue(12); issue(13);
    drive(1'b0, 2'd0, 0, 1'b0, 1'b1);
    read_regs[1] = 6'd3; read_valid = 3'b010;
    write_regs[0] = 6'd12; write_valid = 2'b01;
    settle("release");
    check_eq("release.rdep_c", 32'(read_dep), 32'd0);
    check_eq("release.wdep_c", 32'(write_dep), 32'd1);
    advance();
    issue(14);
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    rst_n = 1'b0; q.delete(); m_lat = 2'd0;
    settle("midreset");
    check_eq("midreset.occ_c", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 0, 1'b0, 1'b1);
    settle("spurious");
    check_eq("spurious.waddr_c", 32'(waddr_o), 32'd0);
    advance();
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    settle("spurious_after");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(1, 3)), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, 1'b0);
      for (int i = 0; i < NR_RREGS; i++) read_regs[i] = ADDR_W'($urandom_range(0, 7));
      for (int i = 0; i < NR_WREGS; i++) write_regs[i] = ADDR_W'($urandom_range(0, 7));
      read_valid  = NR_RREGS'($urandom);
      write_valid = NR_WREGS'($urandom);
      model_eval();
      valid = ($urandom_range(0, 2) == 0) && (q.size() != 0 || e_vreq);
      settle("rnd");
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
